// File: rtl/sprite_blitter.sv
// sprite_blitter
// Copies a sprite rectangle from the atlas ROM into the framebuffer, one pixel
// at a time (READ -> FETCH -> WRITE). Colour-key pixels and pixels that fall
// off the right/bottom screen edge are skipped. write_finished pulses once
// per completed blit; an aborting reset never produces the pulse.
//
// Optional feature macro: BLIT_MIRROR_EN
//   When defined, an extra input 'mirror' is latched on start. A latched
//   mirror=1 reads ROM columns right-to-left (horizontal flip) while screen
//   columns are still written left-to-right.
module sprite_blitter #(
    parameter int               SCREEN_W  = 640,
    parameter int               SCREEN_H  = 480,
    parameter int               ROM_W     = 1024,
    parameter int               PIX_W     = 12,
    parameter int               FB_AW     = 19,
    parameter int               ROM_AW    = 20,
    parameter logic [PIX_W-1:0] KEY_COLOR = 12'hF0F
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef BLIT_MIRROR_EN
    input  logic              mirror,
`endif
    input  logic              start,
    input  logic [11:0]       spr_x,
    input  logic [11:0]       spr_y,
    input  logic [11:0]       spr_w,
    input  logic [11:0]       spr_h,
    input  logic [11:0]       rom_x,
    input  logic [11:0]       rom_y,
    output logic              rom_rd,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              write_finished
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_FETCH = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r,  state_nxt_s;

    // Latched sprite descriptor
    logic [11:0]         sx0_r, sy0_r, w_r, h_r, rx_r, ry_r;
    logic [11:0]         sx0_nxt_s, sy0_nxt_s, w_nxt_s, h_nxt_s, rx_nxt_s, ry_nxt_s;
`ifdef BLIT_MIRROR_EN
    logic                mirror_r, mirror_nxt_s;
`endif

    // Pixel walk counters and the fetched pixel
    logic [11:0]         col_r, row_r, col_nxt_s, row_nxt_s;
    logic [PIX_W-1:0]    pix_r, pix_nxt_s;
    logic                skip_r, skip_nxt_s;

    // Registered outputs
    logic                rom_rd_r;
    logic [ROM_AW-1:0]   rom_addr_r;
    logic                fb_we_r;
    logic [FB_AW-1:0]    fb_addr_r, fb_addr_nxt_s;
    logic                busy_r;
    logic                done_r;

    // Address arithmetic helpers
    logic [12:0]         fetch_sx_s, fetch_sy_s;
    logic [FB_AW-1:0]    fb_full_s;
    logic [11:0]         rom_coff_s;
    logic [12:0]         rom_row_s, rom_col_s;
    logic [ROM_AW-1:0]   rom_full_s;
    logic                last_col_s, last_row_s;

    // Screen coordinates are 13 bits wide so that sx0+col never wraps back on screen.
    assign fetch_sx_s = {1'b0, sx0_r} + {1'b0, col_r};
    assign fetch_sy_s = {1'b0, sy0_r} + {1'b0, row_r};
    assign fb_full_s  = FB_AW'(32'(fetch_sy_s) * 32'(SCREEN_W) + 32'(fetch_sx_s));

    // The ROM address is computed from next-cycle counters so it is registered
    // together with the entry into READ.
`ifdef BLIT_MIRROR_EN
    assign rom_coff_s = mirror_nxt_s ? (w_nxt_s - 12'd1 - col_nxt_s) : col_nxt_s;
`else
    assign rom_coff_s = col_nxt_s;
`endif
    assign rom_row_s  = {1'b0, ry_nxt_s} + {1'b0, row_nxt_s};
    assign rom_col_s  = {1'b0, rx_nxt_s} + {1'b0, rom_coff_s};
    assign rom_full_s = ROM_AW'(32'(rom_row_s) * 32'(ROM_W) + 32'(rom_col_s));

    assign last_col_s = (col_r == (w_r - 12'd1));
    assign last_row_s = (row_r == (h_r - 12'd1));

    // Next-state, descriptor latch, counter advance and fetch-stage decisions
    always_comb begin
        state_nxt_s   = state_r;
        sx0_nxt_s     = sx0_r;
        sy0_nxt_s     = sy0_r;
        w_nxt_s       = w_r;
        h_nxt_s       = h_r;
        rx_nxt_s      = rx_r;
        ry_nxt_s      = ry_r;
`ifdef BLIT_MIRROR_EN
        mirror_nxt_s  = mirror_r;
`endif
        col_nxt_s     = col_r;
        row_nxt_s     = row_r;
        pix_nxt_s     = pix_r;
        skip_nxt_s    = skip_r;
        fb_addr_nxt_s = fb_addr_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    sx0_nxt_s = spr_x;
                    sy0_nxt_s = spr_y;
                    w_nxt_s   = spr_w;
                    h_nxt_s   = spr_h;
                    rx_nxt_s  = rom_x;
                    ry_nxt_s  = rom_y;
`ifdef BLIT_MIRROR_EN
                    mirror_nxt_s = mirror;
`endif
                    col_nxt_s = 12'd0;
                    row_nxt_s = 12'd0;
                    if ((spr_w == 12'd0) || (spr_h == 12'd0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt_s = ST_FETCH;
            end
            ST_FETCH: begin
                pix_nxt_s     = rom_data;
                skip_nxt_s    = (rom_data == KEY_COLOR) ||
                                (fetch_sx_s >= 13'(SCREEN_W)) ||
                                (fetch_sy_s >= 13'(SCREEN_H));
                fb_addr_nxt_s = fb_full_s;
                state_nxt_s   = ST_WRITE;
            end
            ST_WRITE: begin
                // A skipped pixel advances at once; a real write waits for fb_ready.
                if (skip_r || fb_ready) begin
                    if (last_col_s) begin
                        col_nxt_s = 12'd0;
                        row_nxt_s = row_r + 12'd1;
                    end else begin
                        col_nxt_s = col_r + 12'd1;
                    end
                    if (last_col_s && last_row_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_READ;
                    end
                end else begin
                    state_nxt_s = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, descriptor, counters and all output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            sx0_r      <= 12'd0;
            sy0_r      <= 12'd0;
            w_r        <= 12'd0;
            h_r        <= 12'd0;
            rx_r       <= 12'd0;
            ry_r       <= 12'd0;
`ifdef BLIT_MIRROR_EN
            mirror_r   <= 1'b0;
`endif
            col_r      <= 12'd0;
            row_r      <= 12'd0;
            pix_r      <= '0;
            skip_r     <= 1'b0;
            rom_rd_r   <= 1'b0;
            rom_addr_r <= '0;
            fb_we_r    <= 1'b0;
            fb_addr_r  <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            sx0_r      <= sx0_nxt_s;
            sy0_r      <= sy0_nxt_s;
            w_r        <= w_nxt_s;
            h_r        <= h_nxt_s;
            rx_r       <= rx_nxt_s;
            ry_r       <= ry_nxt_s;
`ifdef BLIT_MIRROR_EN
            mirror_r   <= mirror_nxt_s;
`endif
            col_r      <= col_nxt_s;
            row_r      <= row_nxt_s;
            pix_r      <= pix_nxt_s;
            skip_r     <= skip_nxt_s;
            fb_addr_r  <= fb_addr_nxt_s;
            rom_rd_r   <= (state_nxt_s == ST_READ);
            if (state_nxt_s == ST_READ) begin
                rom_addr_r <= rom_full_s;
            end
            fb_we_r    <= (state_nxt_s == ST_WRITE) && !skip_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
            // The completion pulse is the registered image of the DONE state.
            done_r     <= (state_r == ST_DONE);
        end
    end

    assign rom_rd         = rom_rd_r;
    assign rom_addr       = rom_addr_r;
    assign fb_we          = fb_we_r;
    assign fb_addr        = fb_addr_r;
    assign fb_data        = pix_r;
    assign busy           = busy_r;
    assign write_finished = done_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter: directed cases plus randomized blits
// checked against a per-pixel reference model of the copy rules.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] spr_x = 12'd0, spr_y = 12'd0, spr_w = 12'd0, spr_h = 12'd0;
    logic [11:0] rom_x = 12'd0, rom_y = 12'd0;
    logic        rom_rd;
    logic [19:0] rom_addr;
    logic [11:0] rom_data = 12'd0;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [11:0] fb_data;
    logic        fb_ready = 1'b1;
    logic        busy;
    logic        write_finished;
`ifdef BLIT_MIRROR_EN
    logic        mirror = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int wf_cnt = 0;
    int wf_cyc = 0;
    int rd_cnt = 0;
    int stall_cnt = 0;
    logic [30:0] wr_q[$];
    logic [30:0] exp_q[$];
    logic [11:0] rom_ovr[int];

    sprite_blitter dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef BLIT_MIRROR_EN
        .mirror(mirror),
`endif
        .start(start),
        .spr_x(spr_x),
        .spr_y(spr_y),
        .spr_w(spr_w),
        .spr_h(spr_h),
        .rom_x(rom_x),
        .rom_y(rom_y),
        .rom_rd(rom_rd),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .fb_we(fb_we),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .fb_ready(fb_ready),
        .busy(busy),
        .write_finished(write_finished)
    );

    always #5 clk = ~clk;

    // Atlas contents: explicit overrides, otherwise a fixed hash of the address
    function automatic logic [11:0] rom_fn(input logic [19:0] a);
        if (rom_ovr.exists(int'(a))) return rom_ovr[int'(a)];
        return a[11:0] ^ {a[19:12], a[3:0]} ^ 12'h5A3;
    endfunction

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle observer: ROM model, accepted writes, read strobes, completion pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (rom_rd) begin
                rd_cnt++;
                rom_data = rom_fn(rom_addr);
            end
            if (fb_we && fb_ready) wr_q.push_back({fb_addr, fb_data});
            if (fb_we && !fb_ready) stall_cnt++;
            if (write_finished) begin
                wf_cnt++;
                wf_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: walk the rectangle and list every pixel that should land on screen
    task automatic build_expect(input int x, y, w, h, rx, ry, input bit mir);
        logic [19:0] a;
        logic [11:0] p;
        int rc, sx, sy;
        exp_q.delete();
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                rc = mir ? (w - 1 - c) : c;
                a  = 20'((ry + r) * 1024 + rx + rc);
                p  = rom_fn(a);
                sx = x + c;
                sy = y + r;
                if (p != 12'hF0F && sx < 640 && sy < 480)
                    exp_q.push_back({19'(sy * 640 + sx), p});
            end
        end
    endtask

    // mode 0: plain, 1: hold fb_ready low for the first 5 write cycles, 2: start pulsed while busy
    task automatic run_blit(input string tag, input int x, y, w, h, rx, ry, input bit mir,
                            input int mode, input int stall_pct, output int lat);
        int n, wf0, t0, budget, exp_lat, nmin;
        build_expect(x, y, w, h, rx, ry, mir);
        wr_q.delete();
        rd_cnt = 0;
        stall_cnt = 0;
        wf0 = wf_cnt;
        spr_x = 12'(x); spr_y = 12'(y); spr_w = 12'(w); spr_h = 12'(h);
        rom_x = 12'(rx); rom_y = 12'(ry);
`ifdef BLIT_MIRROR_EN
        mirror = mir;
`endif
        start = 1'b1;
        fb_ready = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        spr_x = 12'($urandom); spr_y = 12'($urandom); spr_w = 12'($urandom);
        spr_h = 12'($urandom); rom_x = 12'($urandom); rom_y = 12'($urandom);
        chk({tag, "_busy"}, busy, 1);
        budget = 10 * w * h + 60;
        if (mode == 1) begin
            n = 0;
            while (!fb_we && n < 50) begin tick(); n++; end
            chk({tag, "_bp_reach"}, fb_we, 1);
            for (int k = 0; k < 5; k++) begin
                fb_ready = 1'b0;
                if (k > 0) chk({tag, "_bp_we"}, fb_we, 1);
                chk({tag, "_bp_addr"}, fb_addr, exp_q[0][30:12]);
                chk({tag, "_bp_data"}, fb_data, exp_q[0][11:0]);
                tick();
            end
            fb_ready = 1'b1;
        end
        n = 0;
        while (wf_cnt == wf0 && n < budget) begin
            fb_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            start = (mode == 2 && n < 4);
            tick();
            n++;
        end
        start = 1'b0;
        fb_ready = 1'b1;
        chk({tag, "_timeout"}, wf_cnt != wf0, 1);
        lat = wf_cyc - t0;
        repeat (3) tick();
        chk({tag, "_pulses"}, wf_cnt - wf0, 1);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_reads"}, rd_cnt, w * h);
        chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
        nmin = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) chk({tag, "_wr"}, wr_q[i], exp_q[i]);
        exp_lat = (w == 0 || h == 0) ? 2 : 3 * w * h + 2 + stall_cnt;
        chk({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int lat, n, wf0;
        int rw, rh, rxp, ryp, rxr, ryr;

        // Reset state
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_we", fb_we, 0);
        chk("rst_rd", rom_rd, 0);
        chk("rst_wf", write_finished, 0);
        chk("rst_faddr", fb_addr, 0);
        chk("rst_fdata", fb_data, 0);
        chk("rst_raddr", rom_addr, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Basic 2x2 copy
        rom_ovr.delete();
        rom_ovr[0] = 12'h111; rom_ovr[1] = 12'h222;
        rom_ovr[1024] = 12'h333; rom_ovr[1025] = 12'h444;
        run_blit("basic", 10, 20, 2, 2, 0, 0, 1'b0, 0, 0, lat);
        chk("basic_lat14", lat, 14);
        chk("basic_w0", (wr_q.size() > 0) ? wr_q[0] : 31'd0, {19'd12810, 12'h111});
        chk("basic_w3", (wr_q.size() > 3) ? wr_q[3] : 31'd0, {19'd13451, 12'h444});

        // Colour key
        rom_ovr[1] = 12'hF0F;
        run_blit("key", 10, 20, 2, 2, 0, 0, 1'b0, 0, 0, lat);
        chk("key_cnt3", wr_q.size(), 3);
        rom_ovr[1] = 12'h222;

        // Backpressure on the first write
        run_blit("bp", 10, 20, 2, 2, 0, 0, 1'b0, 1, 0, lat);
        chk("bp_lat19", lat, 19);

        // Clipping at the right edge
        rom_ovr[2] = 12'h0CC;
        run_blit("clip", 639, 100, 3, 1, 0, 0, 1'b0, 0, 0, lat);
        chk("clip_cnt1", wr_q.size(), 1);
        chk("clip_w0", (wr_q.size() > 0) ? wr_q[0] : 31'd0, {19'(100 * 640 + 639), 12'h111});

        // Zero size
        run_blit("zero_w", 5, 5, 0, 3, 0, 0, 1'b0, 0, 0, lat);
        chk("zero_w_lat2", lat, 2);
        run_blit("zero_h", 5, 5, 4, 0, 0, 0, 1'b0, 0, 0, lat);

        // start while busy is ignored
        run_blit("ignore", 10, 20, 2, 2, 0, 0, 1'b0, 2, 0, lat);
        chk("ignore_lat14", lat, 14);

        // Wide sprite clipped at x=640, full 12-bit width counters
        rom_ovr.delete();
        run_blit("wide", 0, 5, 700, 1, 100, 3, 1'b0, 0, 0, lat);

        // Reset mid-blit aborts without a completion pulse
        rom_ovr[0] = 12'h111;
        spr_x = 12'd10; spr_y = 12'd20; spr_w = 12'd3; spr_h = 12'd3;
        rom_x = 12'd0; rom_y = 12'd0;
        wf0 = wf_cnt;
        start = 1'b1;
        fb_ready = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        while (!fb_we && n < 50) begin tick(); n++; end
        chk("abort_reach", fb_we, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_we", fb_we, 0);
        chk("abort_wf", write_finished, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        fb_ready = 1'b1;
        repeat (4) tick();
        chk("abort_nopulse", wf_cnt - wf0, 0);
        chk("abort_idle", busy, 0);

        // Recovery after abort
        rom_ovr.delete();
        rom_ovr[0] = 12'h111; rom_ovr[1] = 12'h222;
        rom_ovr[1024] = 12'h333; rom_ovr[1025] = 12'h444;
        run_blit("recover", 10, 20, 2, 2, 0, 0, 1'b0, 0, 0, lat);

`ifdef BLIT_MIRROR_EN
        // Horizontal flip
        run_blit("mirror", 10, 20, 2, 1, 0, 0, 1'b1, 0, 0, lat);
        chk("mirror_px0", (wr_q.size() > 0) ? wr_q[0] : 31'd0, {19'd12810, 12'h222});
`endif

        // Randomized blits with random backpressure and occasional key pixels
        for (int it = 0; it < 25; it++) begin
            rom_ovr.delete();
            rw  = $urandom_range(5);
            rh  = $urandom_range(4);
            rxp = ($urandom_range(3) == 0) ? $urandom_range(645, 630) : $urandom_range(700);
            ryp = ($urandom_range(3) == 0) ? $urandom_range(482, 474) : $urandom_range(500);
            if ($urandom_range(9) == 0) rxp = $urandom_range(4095, 4000);
            rxr = $urandom_range(4095);
            ryr = $urandom_range(4095);
            if ($urandom_range(1) == 1) rom_ovr[int'(20'(ryr * 1024 + rxr + 1))] = 12'hF0F;
            run_blit("rand", rxp, ryp, rw, rh, rxr, ryr, 1'b0, 0, 30, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
